// File: rtl/reg_bank_pkg.sv
// Shared constants and enumerations for the register bank A write controller.
package reg_bank_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 14;
  localparam int AW    = 4;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } wr_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    APPLY = 2'b01,
    RESP  = 2'b10
  } wr_state_t;

endpackage

// File: rtl/reg_bank_op.sv
// Combinational read-modify-write operator: new = op(old, data), full width, no carries.
module reg_bank_op
  import reg_bank_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] old_val,
  input  logic [W-1:0] data,
  input  wr_op_t       op,
  output logic [W-1:0] new_val
);

  always_comb begin
    // NOTE: default assigned before the case so no path can leave new_val unassigned (no latch).
    new_val = old_val;
    case (op)
      OP_WRITE:  new_val = data;
      OP_SET:    new_val = old_val | data;
      OP_CLEAR:  new_val = old_val & ~data;
      OP_TOGGLE: new_val = old_val ^ data;
      default:   new_val = old_val;
    endcase
  end

endmodule

// File: rtl/reg_bank_wr.sv
// Write-side controller for register bank A: valid/ready request, 3-state FSM,
// 14 x 16-bit registers flattened onto regs_flat, saturating success counter.
module reg_bank_wr
  import reg_bank_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [1:0]             wr_op,
  output logic                   resp_valid,
  output logic                   resp_err,
  input  logic                   resp_ready,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic [7:0]             wr_count
);

  wr_state_t        state_q, state_d;
  logic [AW-1:0]    hold_addr;
  logic [WIDTH-1:0] hold_data;
  wr_op_t           hold_op;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] old_val, new_val;
  logic             addr_ok;
  logic             accept;

  assign wr_ready   = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = wr_ready & wr_valid;
  assign addr_ok    = (hold_addr < AW'(NREGS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_valid) state_d = APPLY;
      APPLY:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr <= '0;
      hold_data <= '0;
      hold_op   <= OP_WRITE;
    end else if (accept) begin
      hold_addr <= wr_addr;
      hold_data <= wr_data;
      hold_op   <= wr_op_t'(wr_op);
    end
  end

  // Read mux over the array; out-of-range addresses read as zero and are never written.
  always_comb begin
    old_val = '0;
    for (int i = 0; i < NREGS; i++)
      if (hold_addr == AW'(i)) old_val = regs[i];
  end

  reg_bank_op #(.W(WIDTH)) u_op (
    .old_val (old_val),
    .data    (hold_data),
    .op      (hold_op),
    .new_val (new_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is built from flops, not RAM, so it can and must clear on reset.
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state_q == APPLY && addr_ok) begin
      for (int i = 0; i < NREGS; i++)
        if (hold_addr == AW'(i)) regs[i] <= new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err <= 1'b0;
      wr_count <= '0;
    end else if (state_q == APPLY) begin
      resp_err <= !addr_ok;
      if (addr_ok && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_pack
    assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: doc/reg_bank_wr.md
# reg_bank_wr

Write-side controller for register bank A: accepts single-beat write requests over a valid/ready handshake, decodes a 4-bit address onto 14 16-bit registers, applies a write/set/clear/toggle operation, and returns a one-beat response with an error flag. Its flattened register outputs drive the 14 data inputs of the bank's read multiplexer, so it forms the write end of the same 4-bit-addressed, 16-bit register interface.

## Interface
- `WIDTH`, 16: register width in bits
- `NREGS`, 14: number of implemented registers (addresses 0..NREGS-1)
- `AW`, 4: address width
- `clk`  in  1: single clock, rising edge
- `rst_n`  in  1: asynchronous, active-low reset
- `wr_valid`  in  1: request valid
- `wr_ready`  out  1: controller can accept a request
- `wr_addr`  in  AW: target register
- `wr_data`  in  WIDTH: operand
- `wr_op`  in  2: 00 WRITE, 01 SET (OR), 10 CLEAR (AND NOT), 11 TOGGLE (XOR)
- `resp_valid`  out  1: response valid
- `resp_err`  out  1: 1 = address out of range, no register changed
- `resp_ready`  in  1: response consumer ready
- `regs_flat`  out  NREGS*WIDTH: register i at bits [i*WIDTH +: WIDTH]
- `wr_count`  out  8: successful-operation counter, saturating

## Operation
- FSM states: IDLE, APPLY, RESP.
- IDLE: `wr_ready`=1. On `wr_valid & wr_ready`, capture addr/data/op into holding registers, go to APPLY.
- APPLY: if addr < NREGS, reg[addr] <= op(reg[addr], data), `resp_err` <= 0, `wr_count` += 1 (held at 255 once reached); else no register change, `resp_err` <= 1, count unchanged. Go to RESP.
- RESP: `resp_valid`=1; stay until `resp_ready`=1, then go to IDLE.
- `wr_ready` decoded from the state only, never from `wr_valid`. No combinational path from any input to any output.
- Op results are full WIDTH bits; no carries, no sign handling.
- Inputs are ignored outside the IDLE handshake; changing `wr_addr`/`wr_data` after acceptance has no effect.
- Addresses 14 and 15 return an error. A read of those addresses on the read side returns 0.

## Timing
- Reset (asynchronous assert, synchronous-style release on `clk`): state IDLE, all registers 0, `regs_flat`=0, `wr_ready`=1, `resp_valid`=0, `resp_err`=0, `wr_count`=0.
- Accept at edge N. Register updated and visible on `regs_flat` after edge N+1. `resp_valid` high after edge N+1.
- With `resp_ready`=1, the handshake completes at edge N+2, `wr_ready`=1 after N+2, and the next accept is at N+3. Peak throughput is one operation per 3 cycles.
- If `resp_ready` is held low, RESP holds indefinitely with `resp_valid`, `resp_err` and `regs_flat` stable.
- Reset mid-transaction (APPLY or RESP) discards the transaction with no response. Registers and count clear regardless of progress.
- A `wr_valid` pulse during APPLY or RESP is not accepted. The requester must hold it until it sees `wr_ready`.

## Structure
- Package `reg_bank_pkg`: `WIDTH`, `NREGS`, `AW` constants; `wr_op_t` enum (OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE); `wr_state_t` enum (IDLE, APPLY, RESP).
- Sub-module `reg_bank_op`: combinational (old, data, op) -> new, WIDTH bits.
- Top: FSM, holding registers, register array with generate-based packing into `regs_flat`, counter.

## Test plan
- Reset, then WRITE addr 3 data 16'hA5A5 with `resp_ready`=1: reg3=A5A5 after edge N+1, `resp_err`=0, `wr_count`=1, `wr_ready` back high after N+2.
- On reg3=A5A5: SET 16'h0F00 gives AF A5 (16'hAFA5); CLEAR 16'h00A5 gives 16'hAF00; TOGGLE 16'hFFFF gives 16'h50FF. Other registers stay 0.
- WRITE addr 14 data 16'h1234: `resp_err`=1, all registers unchanged, `wr_count` unchanged. Repeat for addr 15.
- `resp_ready` held low for 10 cycles: `resp_valid` stays 1, `wr_ready` stays 0, and a second `wr_valid` is not accepted until 1 cycle after the response handshake.
- 260 successful WRITEs: `wr_count` saturates at 255. WRITE to addr 13 data 16'hBEEF appears at `regs_flat[223:208]`.
- Assert `rst_n`=0 while in RESP: `resp_valid`=0, `regs_flat`=0, `wr_count`=0 immediately, without waiting for a clock edge. After release, the controller is in IDLE with `wr_ready`=1.
